// File: rtl/otg_hpi_arbiter_if.sv
// rtl/otg_hpi_arbiter_if.sv - requester ports and HPI chip pins of otg_hpi_arbiter
// slave = arbiter side, master = requesters plus chip model.
interface otg_hpi_arbiter_if;
   logic        m0_req, m0_we, m0_ack;
   logic [1:0]  m0_addr;
   logic [15:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_ack;
   logic [1:0]  m1_addr;
   logic [15:0] m1_wdata, m1_rdata;
   logic [1:0]  hpi_addr;
   logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_doe;
   logic [15:0] hpi_dout, hpi_din;
   logic        busy, grant;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, hpi_din,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_dout, hpi_doe, busy, grant
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata, hpi_din,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_dout, hpi_doe, busy, grant
   );
endinterface

// File: rtl/otg_hpi_arbiter.sv
// rtl/otg_hpi_arbiter.sv - two-port arbiter and strobe sequencer for the CY7C67200 HPI bus
// Define HPI_ARB_FIXED_PRIO_EN to give m1 fixed priority instead of round-robin.
module otg_hpi_arbiter #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 1,
   parameter int REC_CYC    = 2
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   otg_hpi_arbiter_if.slave bus
);
   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
   localparam logic [3:0] REC_LD    = 4'(REC_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER} state_t;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       win;
   logic       we_q;

`ifdef HPI_ARB_FIXED_PRIO_EN
   always_comb win = bus.m1_req;
`else
   logic last_served;

   // A tie goes to whichever port was not served last.
   always_comb win = (bus.m0_req && bus.m1_req) ? !last_served : bus.m1_req;

   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         last_served <= 1'b1;
      else if (state == S_IDLE && state_n == S_SETUP)
         last_served <= win;
   end
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      case (state)
         S_IDLE:
            if (bus.m0_req || bus.m1_req) begin
               state_n = S_SETUP;
               cnt_n   = SETUP_LD;
            end
         S_SETUP:
            if (cnt == 4'd0) begin
               state_n = S_STROBE;
               cnt_n   = STROBE_LD;
            end
         S_STROBE:
            if (cnt == 4'd0) begin
               state_n = S_HOLD;
               cnt_n   = HOLD_LD;
            end
         S_HOLD:
            if (cnt == 4'd0) begin
               state_n = S_RECOVER;
               cnt_n   = REC_LD;
            end
         S_RECOVER:
            if (cnt == 4'd0)
               state_n = S_IDLE;
         default: begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // Outputs are registered off the next state so pins move exactly on state boundaries.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bus.hpi_cs_n <= 1'b1;
         bus.hpi_r_n  <= 1'b1;
         bus.hpi_w_n  <= 1'b1;
         bus.hpi_doe  <= 1'b0;
         bus.hpi_addr <= 2'd0;
         bus.hpi_dout <= 16'd0;
         bus.m0_ack   <= 1'b0;
         bus.m1_ack   <= 1'b0;
         bus.m0_rdata <= 16'd0;
         bus.m1_rdata <= 16'd0;
         bus.busy     <= 1'b0;
         bus.grant    <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         bus.busy   <= (state_n != S_IDLE);
         bus.m0_ack <= (state_n == S_HOLD) && (cnt_n == 4'd0) && !bus.grant;
         bus.m1_ack <= (state_n == S_HOLD) && (cnt_n == 4'd0) && bus.grant;
         case (state)
            S_IDLE:
               if (state_n == S_SETUP) begin
                  bus.grant    <= win;
                  we_q         <= win ? bus.m1_we : bus.m0_we;
                  bus.hpi_addr <= win ? bus.m1_addr : bus.m0_addr;
                  bus.hpi_dout <= win ? bus.m1_wdata : bus.m0_wdata;
                  bus.hpi_doe  <= win ? bus.m1_we : bus.m0_we;
                  bus.hpi_cs_n <= 1'b0;
               end
            S_SETUP:
               if (cnt == 4'd0) begin
                  bus.hpi_r_n <= we_q;
                  bus.hpi_w_n <= !we_q;
               end
            S_STROBE:
               if (cnt == 4'd0) begin
                  bus.hpi_r_n <= 1'b1;
                  bus.hpi_w_n <= 1'b1;
                  if (!we_q) begin
                     if (bus.grant)
                        bus.m1_rdata <= bus.hpi_din;
                     else
                        bus.m0_rdata <= bus.hpi_din;
                  end
               end
            S_HOLD:
               if (cnt == 4'd0) begin
                  bus.hpi_cs_n <= 1'b1;
                  bus.hpi_doe  <= 1'b0;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_otg_hpi_arbiter.sv
// tb/tb_otg_hpi_arbiter.sv - randomized bench for otg_hpi_arbiter against a timing-formula model
// Honours HPI_ARB_FIXED_PRIO_EN when predicting tie winners.
module tb_otg_hpi_arbiter;
   localparam int S = 1, ST = 4, H = 1, R = 2;
   localparam int PER = S + ST + H + R + 1;

   logic clk = 1'b0;
   logic reset_reset;
   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;

   otg_hpi_arbiter_if bus ();
   otg_hpi_arbiter_if bus2 ();

   otg_hpi_arbiter dut (.clk_clk(clk), .reset_reset(reset_reset), .bus(bus));
   otg_hpi_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .REC_CYC(1))
      dut2 (.clk_clk(clk), .reset_reset(reset_reset), .bus(bus2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // requester intent
   bit          pend [2];
   bit          pwe  [2];
   logic [1:0]  paddr[2];
   logic [15:0] pwd  [2];
   int          refill[2];
   // model of the current access
   bit          act, g, jwe, last_srv, grant_e;
   int          t0;
   logic [1:0]  exp_addr;
   logic [15:0] exp_dout, cap;
   logic [15:0] mrd[2];
   // scenario controls
   bit          rst_req, rand_mode, din_force_en;
   logic [15:0] din_force;
   int          ack_cyc[$], start_cyc[$];
   bit          ack_who[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit pick_winner();
`ifdef HPI_ARB_FIXED_PRIO_EN
      return pend[1];
`else
      return (pend[0] && pend[1]) ? !last_srv : pend[1];
`endif
   endfunction

   task automatic tick();
      int rel;
      bit idle_now, cs_lo, stb, ack_c, busy_e;
      logic [15:0] din;
      @(negedge clk);
      idle_now = !act;
      rel      = act ? (cyc - t0) : -1;
      cs_lo    = act && rel >= 1 && rel <= S + ST + H;
      stb      = act && rel >= S + 1 && rel <= S + ST;
      ack_c    = act && rel == S + ST + H;
      busy_e   = act && rel >= 1 && rel <= PER - 1;
      check_eq("cs_n", bus.hpi_cs_n, !cs_lo);
      check_eq("r_n", bus.hpi_r_n, !(stb && !jwe));
      check_eq("w_n", bus.hpi_w_n, !(stb && jwe));
      check_eq("doe", bus.hpi_doe, cs_lo && jwe);
      check_eq("busy", bus.busy, busy_e);
      check_eq("m0_ack", bus.m0_ack, ack_c && !g);
      check_eq("m1_ack", bus.m1_ack, ack_c && g);
      check_eq("grant", bus.grant, grant_e);
      check_eq("hpi_addr", bus.hpi_addr, exp_addr);
      check_eq("hpi_dout", bus.hpi_dout, exp_dout);
      if (bus.m0_ack || bus.m1_ack) begin
         ack_cyc.push_back(cyc);
         ack_who.push_back(bus.m1_ack);
      end
      if (ack_c) begin
         if (!jwe) mrd[g] = cap;
         pend[g] = 1'b0;
         if (refill[g] > 0) begin
            refill[g]--;
            pend[g] = 1'b1;
         end
      end
      if (ack_c || !act) begin
         check_eq("m0_rdata", bus.m0_rdata, mrd[0]);
         check_eq("m1_rdata", bus.m1_rdata, mrd[1]);
      end
      if (act && rel == PER - 1) act = 1'b0;
      if (rst_req) begin
         act = 1'b0; last_srv = 1'b1; grant_e = 1'b0;
         exp_addr = '0; exp_dout = '0; mrd[0] = '0; mrd[1] = '0;
      end else begin
         if (rand_mode) begin
            for (int i = 0; i < 2; i++)
               if (!pend[i] && $urandom_range(0, 3) == 0) begin
                  pend[i] = 1'b1; pwe[i] = 1'($urandom);
                  paddr[i] = 2'($urandom); pwd[i] = 16'($urandom);
               end
            // the owner's inputs are don't-care once latched
            if (act && pend[g]) begin
               pwd[g] = 16'($urandom); paddr[g] = 2'($urandom);
            end
         end
         if (idle_now && (pend[0] || pend[1])) begin
            g = pick_winner();
            jwe = pwe[g]; exp_addr = paddr[g]; exp_dout = pwd[g];
            grant_e = g; last_srv = g; act = 1'b1; t0 = cyc;
            start_cyc.push_back(cyc);
         end
      end
      din = din_force_en ? din_force : 16'($urandom);
      if (act && cyc - t0 == S + ST) cap = din;
      reset_reset   = rst_req;
      bus.hpi_din   = din;
      bus.m0_req    = pend[0]; bus.m0_we = pwe[0]; bus.m0_addr = paddr[0]; bus.m0_wdata = pwd[0];
      bus.m1_req    = pend[1]; bus.m1_we = pwe[1]; bus.m1_addr = paddr[1]; bus.m1_wdata = pwd[1];
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      do begin
         tick();
         k++;
      end while ((act || pend[0] || pend[1]) && k < max_cyc);
      check_eq("drain", act || pend[0] || pend[1], 1'b0);
   endtask

   task automatic set_job(input int i, input bit we, input logic [1:0] a, input logic [15:0] d);
      pend[i] = 1'b1; pwe[i] = we; paddr[i] = a; pwd[i] = d;
   endtask

   initial begin
      bit exp_seq[4];
      int t2;
      reset_reset = 1'b1; rst_req = 1'b1; rand_mode = 1'b0; din_force_en = 1'b0; din_force = '0;
      act = 0; g = 0; jwe = 0; last_srv = 1; grant_e = 0; t0 = 0;
      exp_addr = '0; exp_dout = '0; cap = '0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pwd[i] = '0; refill[i] = 0; mrd[i] = '0;
      end
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.hpi_din = '0;
      bus2.m0_req = 0; bus2.m0_we = 0; bus2.m0_addr = '0; bus2.m0_wdata = '0;
      bus2.m1_req = 0; bus2.m1_we = 0; bus2.m1_addr = '0; bus2.m1_wdata = '0; bus2.hpi_din = '0;

      // reset held with both requests pending
      set_job(0, 1'b1, 2'd1, 16'h1111);
      set_job(1, 1'b0, 2'd3, 16'h2222);
      repeat (3) tick();
      rst_req = 1'b0;
      ack_cyc.delete(); ack_who.delete(); start_cyc.delete();
      drain(40);
`ifdef HPI_ARB_FIXED_PRIO_EN
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      if (ack_cyc.size() >= 1 && start_cyc.size() >= 1) begin
         check_eq("first_owner", ack_who[0], exp_seq[0]);
         check_eq("first_ack_latency", ack_cyc[0] - start_cyc[0], 32'd6);
      end else
         check_eq("first_ack_seen", ack_cyc.size(), 32'd1);

      // single m0 write
      set_job(0, 1'b1, 2'd2, 16'h1234);
      drain(20);

      // single m1 read with fixed chip data
      din_force_en = 1'b1; din_force = 16'hBEEF;
      set_job(1, 1'b0, 2'd1, 16'h0);
      drain(20);
      din_force_en = 1'b0;
      check_eq("m1_rdata_beef", bus.m1_rdata, 16'hBEEF);

      // contention: four back-to-back accesses
      ack_cyc.delete(); ack_who.delete();
      set_job(0, 1'b0, 2'd0, 16'hAAAA);
      set_job(1, 1'b1, 2'd3, 16'h5555);
      refill[0] = 2; refill[1] = 3;
      drain(100);
      if (ack_cyc.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("contend_owner%0d", k), ack_who[k], exp_seq[k]);
            if (k > 0) check_eq($sformatf("contend_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], PER);
         end
      end else
         check_eq("contend_acks", ack_cyc.size(), 32'd4);

      // reset in the second strobe cycle abandons the access
      set_job(1, 1'b0, 2'd2, 16'h0);
      repeat (3) tick();
      rst_req = 1'b1; pend[1] = 1'b0;
      tick();
      rst_req = 1'b0;
      tick();
      set_job(0, 1'b1, 2'd3, 16'hC0DE);
      drain(20);

      // randomized traffic
      rand_mode = 1'b1;
      repeat (600) tick();
      rand_mode = 1'b0;
      drain(40);

      // non-default timing on the second instance
      tick();
      bus2.m0_req = 1'b1; bus2.m0_we = 1'b0; bus2.m0_addr = 2'd1; bus2.hpi_din = 16'h5A5A;
      t2 = cyc;
      for (int r = 1; r <= 10; r++) begin
         tick();
         check_eq($sformatf("t2_r_n@%0d", r), bus2.hpi_r_n, !(cyc - t2 == 4));
         check_eq($sformatf("t2_w_n@%0d", r), bus2.hpi_w_n, 1'b1);
         check_eq($sformatf("t2_ack@%0d", r), bus2.m0_ack, cyc - t2 == 6);
         check_eq($sformatf("t2_busy@%0d", r), bus2.busy, (cyc - t2 <= 7) || (cyc - t2 >= 9));
         check_eq($sformatf("t2_cs_n@%0d", r), bus2.hpi_cs_n, (cyc - t2 == 7) || (cyc - t2 == 8));
         if (cyc - t2 == 6) check_eq("t2_rdata", bus2.m0_rdata, 16'h5A5A);
      end
      bus2.m0_req = 1'b0;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/otg_hpi_arbiter.md
# otg_hpi_arbiter

Sequencer and two-port arbiter for the single CY7C67200 HPI bus. It sits between the Nios-side HPI bridge (requester m0) and the hardware keycode poller (requester m1), and the external OTG chip pins. It grants one requester at a time and drives the chip-select, read and write strobes with parameterised setup, strobe, hold and recovery timing. It returns read data and a one-cycle acknowledge to the granted requester.

## Interface
- SETUP_CYC, 1, cycles with CS low and address/data valid before the strobe falls (legal 1..15)
- STROBE_CYC, 4, cycles the R_N or W_N strobe is held low (legal 1..15)
- HOLD_CYC, 1, cycles after the strobe rises with CS still low (legal 1..15)
- REC_CYC, 2, recovery cycles with CS high before the next grant (legal 1..15)

Ports:
- clk_clk  in  1  system clock; every output is registered on its rising edge
- reset_reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; sampled only in IDLE
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  2  HPI register select
- m0_wdata, m1_wdata  in  16  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  16  read data; valid while the matching ack is high
- hpi_addr  out  2  to otg_hpi_address
- hpi_cs_n, hpi_r_n, hpi_w_n  out  1  active-low chip strobes
- hpi_dout  out  16  to the chip data bus
- hpi_doe  out  1  data-bus output enable; high only during a write
- hpi_din  in  16  from the chip data bus
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the current or most recent owner

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE. Each timed state loads a 4-bit down-counter with its parameter minus 1 and exits when the counter reaches 0.
- **IDLE:** if any req is high, choose a winner and go to SETUP.
  - Latch the winner's we, addr and wdata, and set grant.
  - Load hpi_addr and hpi_dout; drive hpi_cs_n=0; drive hpi_doe=we.
- **Arbitration:** round-robin.
  - A single requester wins directly.
  - When both request, the one not served last wins.
  - After reset, last-served = m1, so m0 wins the first tie.
- **STROBE:** hpi_r_n=0 for a read, or hpi_w_n=0 for a write.
  - On the last STROBE cycle, hpi_din is captured into the rdata register of the granted port.
  - On a write, the rdata register is unchanged.
- **HOLD:** both strobes are high; CS, address and data are held.
  - The granted ack is pulsed on the last HOLD cycle.
- **RECOVER:** hpi_cs_n=1 and hpi_doe=0; lasts REC_CYC cycles.
- **Requester rule:** drop req within REC_CYC cycles of seeing ack. A req still high in IDLE is treated as a new access.
- The non-granted requester's req, addr and wdata are ignored until IDLE.
- **Reset values:** state IDLE; hpi_cs_n, hpi_r_n, hpi_w_n = 1; hpi_doe=0; hpi_addr=0; hpi_dout=0; both acks 0; both rdata 0; busy=0; grant=0; last-served=m1.
- **Reset mid-access:** all of the above take effect at the next edge. No ack is issued and the access is abandoned.

## Timing
- Let T0 be the IDLE cycle in which req is sampled high.
  - The strobe is low during cycles T0+SETUP_CYC+1 through T0+SETUP_CYC+STROBE_CYC.
  - ack is high in cycle T0+SETUP_CYC+STROBE_CYC+HOLD_CYC. With defaults this is T0+6.
- IDLE is re-entered REC_CYC cycles after ack. With defaults, the earliest next sample is T0+9.
- Back-to-back period per access = SETUP_CYC+STROBE_CYC+HOLD_CYC+REC_CYC+1 cycles (9 with defaults).
- hpi_r_n and hpi_w_n are never low in the same cycle. Neither is low while hpi_cs_n=1.
- hpi_addr, hpi_dout and hpi_doe change only on IDLE→SETUP and on HOLD→RECOVER.

## Configuration
- HPI_ARB_FIXED_PRIO_EN defined: the round-robin pointer is removed and m1 (the poller) always wins a tie.
- Undefined: round-robin as described under Operation.
- A single request behaves identically either way.

## Test plan
- **Reset state:** hold reset_reset for 3 cycles with both reqs high. All outputs stay at reset values and no ack fires. After release, m0 is granted first and m0_ack appears at T0+6.
- **m0 write:** addr=2, wdata=0x1234, defaults. hpi_w_n is low for exactly 4 cycles with hpi_dout=0x1234 and hpi_doe=1. hpi_r_n stays 1. m0_ack is high at T0+6.
- **m1 read:** chip drives hpi_din=0xBEEF during the strobe. m1_rdata=0xBEEF with m1_ack. m0_rdata is unchanged.
- **Contention:** both reqs held high for 4 accesses. Grants go m0, m1, m0, m1, each ack 9 cycles apart. With HPI_ARB_FIXED_PRIO_EN, all 4 accesses go to m1.
- **Reset during STROBE:** assert reset in the second strobe cycle. Next edge: hpi_cs_n=1, hpi_r_n=1, busy=0, no ack. A new req then completes normally.
- **Non-default timing:** set SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, REC_CYC=1 on a single read. The strobe is low in T0+4 only, ack is high at T0+6, and the next sample is at T0+8.
